// File: rtl/rv32i_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_wb_pkg
// Description : Shared Wishbone bus widths, arbiter mode and state encodings,
//               plus small index helpers used by the N-master arbiter.
// Revision    : 1.0 - initial N-master arbiter support
// ============================================================================
package rv32i_wb_pkg;

    localparam int WB_ADDR_WIDTH = 32;
    localparam int WB_DATA_WIDTH = 32;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ABORT = 2'd2
    } arb_state_e;

    // Width of an index into n items; never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // (base + k) modulo n, for 0 <= base < n and 0 < k <= n.
    function automatic int wrap_idx(input int base, input int k, input int n);
        int s;
        s = base + k;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv32i_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_rr_picker
// Description : Rotating-priority request picker. Scans from i_ptr+1 upward,
//               wrapping, and returns the first set request as a one-hot
//               grant plus its index. With i_ptr tied to N-1 the scan starts
//               at 0, which gives plain lowest-index-wins priority.
// Ports       : i_req   [N]  request vector
//               i_ptr   [IW] index of the most recently served requester
//               o_gnt   [N]  one-hot winner, zero when no request
//               o_idx   [IW] index of the winner (0 when none)
//               o_valid      at least one request present
// Revision    : 1.0 - initial
// ============================================================================
module rv32i_rr_picker
    import rv32i_wb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        // k = N lands back on i_ptr itself, so the last-served master is
        // still eligible when nobody else is asking.
        for (int k = 1; k <= N; k++) begin
            if (!o_valid && i_req[wrap_idx(int'(i_ptr), k, N)]) begin
                o_valid = 1'b1;
                o_gnt[wrap_idx(int'(i_ptr), k, N)] = 1'b1;
                o_idx   = IW'(wrap_idx(int'(i_ptr), k, N));
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rv32i_wb_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_wb_arbiter_n
// Description : N-master pipelined Wishbone arbiter onto a single downstream
//               bus. Fixed-priority or round-robin selection, grant held for
//               the owner's whole CYC, per-grant stall/ack watchdog.
// Ports       : clk_i, rst_ni (async, active-low)
//               m_*_i / m_*_o : per-master Wishbone ports, master i at slice i
//               bus_*_o / bus_*_i : downstream Wishbone port
//               grant_o   : one-hot registered owner, zero when idle
//               timeout_o : one-cycle pulse when the watchdog aborts a grant
// Revision    : 1.0 - initial N-master version
// ============================================================================
module rv32i_wb_arbiter_n
    import rv32i_wb_pkg::*;
#(
    parameter int        N_MASTERS      = 4,
    parameter int        ADDR_WIDTH     = WB_ADDR_WIDTH,
    parameter int        DATA_WIDTH     = WB_DATA_WIDTH,
    parameter arb_mode_e ARB_MODE       = ARB_FIXED,
    parameter int        TIMEOUT_CYCLES = 256
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    // masters
    input  logic [N_MASTERS-1:0]              m_cyc_i,
    input  logic [N_MASTERS-1:0]              m_stb_i,
    input  logic [N_MASTERS-1:0]              m_we_i,
    input  logic [N_MASTERS*DATA_WIDTH/8-1:0] m_sel_i,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0]   m_adr_i,
    input  logic [N_MASTERS*DATA_WIDTH-1:0]   m_dat_i,
    output logic [DATA_WIDTH-1:0]             m_dat_o,
    output logic [N_MASTERS-1:0]              m_ack_o,
    output logic [N_MASTERS-1:0]              m_err_o,
    output logic [N_MASTERS-1:0]              m_stall_o,
    // downstream bus
    output logic                              bus_cyc_o,
    output logic                              bus_stb_o,
    output logic                              bus_we_o,
    output logic [DATA_WIDTH/8-1:0]           bus_sel_o,
    output logic [ADDR_WIDTH-1:0]             bus_adr_o,
    output logic [DATA_WIDTH-1:0]             bus_dat_o,
    input  logic [DATA_WIDTH-1:0]             bus_dat_i,
    input  logic                              bus_ack_i,
    input  logic                              bus_err_i,
    input  logic                              bus_stall_i,
    // status
    output logic [N_MASTERS-1:0]              grant_o,
    output logic                              timeout_o
);

    localparam int IW = idx_width(N_MASTERS);
    localparam int SW = DATA_WIDTH / 8;
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [TW-1:0] c_TMR_MAX = '1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_e           r_state, w_state_nxt;
    logic [N_MASTERS-1:0] r_grant, w_grant_nxt;
    logic [IW-1:0]        r_owner, w_owner_nxt;
    logic [IW-1:0]        r_rr_ptr, w_rr_ptr_nxt;
    logic [TW-1:0]        r_timer, w_timer_nxt;

    logic [N_MASTERS-1:0] w_req;
    logic [N_MASTERS-1:0] w_pick_gnt;
    logic [IW-1:0]        w_pick_idx;
    logic [IW-1:0]        w_pick_ptr;
    logic                 w_pick_valid;

    logic                  w_own_cyc;
    logic                  w_own_stb;
    logic                  w_own_we;
    logic [SW-1:0]         w_own_sel;
    logic [ADDR_WIDTH-1:0] w_own_adr;
    logic [DATA_WIDTH-1:0] w_own_dat;

    logic w_resp;
    logic w_wd_fire;

    assign w_req  = m_cyc_i & m_stb_i;
    assign w_resp = bus_ack_i | bus_err_i;

    // ------------------------------------------------------------------
    // Winner selection. Fixed priority reuses the rotating picker with
    // the pointer parked at N-1 so the scan always begins at master 0.
    // ------------------------------------------------------------------
    if (ARB_MODE == ARB_RR) begin : g_rr_ptr
        assign w_pick_ptr = r_rr_ptr;
    end else begin : g_fixed_ptr
        assign w_pick_ptr = IW'(N_MASTERS - 1);
    end

    rv32i_rr_picker #(
        .N  (N_MASTERS),
        .IW (IW)
    ) u_picker (
        .i_req   (w_req),
        .i_ptr   (w_pick_ptr),
        .o_gnt   (w_pick_gnt),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    // ------------------------------------------------------------------
    // Owner signal mux
    // ------------------------------------------------------------------
    always_comb begin
        w_own_cyc = 1'b0;
        w_own_stb = 1'b0;
        w_own_we  = 1'b0;
        w_own_sel = '0;
        w_own_adr = '0;
        w_own_dat = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (r_owner == IW'(i)) begin
                w_own_cyc = m_cyc_i[i];
                w_own_stb = m_stb_i[i];
                w_own_we  = m_we_i[i];
                w_own_sel = m_sel_i[i*SW +: SW];
                w_own_adr = m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_own_dat = m_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // Watchdog. A response in the firing cycle wins over the timeout, and
    // an owner releasing CYC ends the grant normally.
    // ------------------------------------------------------------------
    if (TIMEOUT_CYCLES > 0) begin : g_wd
        localparam logic [TW-1:0] c_TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
        assign w_wd_fire = (r_state == ST_BUSY) && w_own_cyc && !w_resp &&
                           (r_timer == c_TMO_LAST);
    end else begin : g_no_wd
        assign w_wd_fire = 1'b0;
    end

    // ------------------------------------------------------------------
    // FSM: registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_owner  <= '0;
            r_rr_ptr <= IW'(N_MASTERS - 1);
            r_timer  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_timer  <= w_timer_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_owner_nxt  = r_owner;
        w_rr_ptr_nxt = r_rr_ptr;
        w_timer_nxt  = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt  = ST_BUSY;
                    w_grant_nxt  = w_pick_gnt;
                    w_owner_nxt  = w_pick_idx;
                    w_rr_ptr_nxt = w_pick_idx;
                end
            end
            ST_BUSY: begin
                if (!w_own_cyc) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                end else if (w_wd_fire) begin
                    w_state_nxt = ST_ABORT;
                end else if (!w_resp) begin
                    w_timer_nxt = (r_timer == c_TMR_MAX) ? r_timer : r_timer + 1'b1;
                end
            end
            ST_ABORT: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs. Responses reach the owner only while BUSY, so stray acks
    // in IDLE/ABORT are dropped.
    // ------------------------------------------------------------------
    always_comb begin
        bus_cyc_o = 1'b0;
        bus_stb_o = 1'b0;
        bus_we_o  = 1'b0;
        bus_sel_o = '0;
        bus_adr_o = '0;
        bus_dat_o = '0;
        m_ack_o   = '0;
        m_err_o   = '0;
        m_stall_o = w_req;
        timeout_o = 1'b0;
        unique case (r_state)
            ST_BUSY: begin
                bus_cyc_o = w_own_cyc;
                bus_stb_o = w_own_stb;
                bus_we_o  = w_own_we;
                bus_sel_o = w_own_sel;
                bus_adr_o = w_own_adr;
                bus_dat_o = w_own_dat;
                m_ack_o   = r_grant & {N_MASTERS{bus_ack_i}};
                m_err_o   = r_grant & {N_MASTERS{bus_err_i}};
                m_stall_o = (w_req & ~r_grant) | (r_grant & {N_MASTERS{bus_stall_i}});
            end
            ST_ABORT: begin
                m_err_o   = r_grant;
                timeout_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign m_dat_o = bus_dat_i;
    assign grant_o = r_grant;

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------
    a_grant_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(grant_o));
    a_resp_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(m_ack_o | m_err_o));
    a_cyc_has_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus_cyc_o |-> (grant_o != '0));

endmodule
`default_nettype wire

// File: tb/tb_rv32i_wb_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32i_wb_arbiter_n
// Description : Directed self-checking bench. One fixed-priority and one
//               round-robin arbiter share the same stimulus; each scenario
//               checks the instance it targets.
// Revision    : 1.0 - initial
// ============================================================================
module tb_rv32i_wb_arbiter_n;
    import rv32i_wb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk;
    logic            rst_ni;
    logic [N-1:0]    m_cyc, m_stb, m_we;
    logic [N*DW/8-1:0] m_sel;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat;
    logic [DW-1:0]   bus_dat_in;
    logic            bus_ack, bus_err, bus_stall;

    // fixed-priority instance outputs
    logic [DW-1:0]   f_mdat;
    logic [N-1:0]    f_ack, f_err, f_stall, f_grant;
    logic            f_cyc, f_stb, f_we, f_timeout;
    logic [DW/8-1:0] f_sel;
    logic [AW-1:0]   f_adr;
    logic [DW-1:0]   f_dat;

    // round-robin instance outputs
    logic [DW-1:0]   r_mdat;
    logic [N-1:0]    r_ack, r_err, r_stall, r_grant;
    logic            r_cyc, r_stb, r_we, r_timeout;
    logic [DW/8-1:0] r_sel;
    logic [AW-1:0]   r_adr;
    logic [DW-1:0]   r_dat;

    int n_checks = 0;
    int n_fail   = 0;

    rv32i_wb_arbiter_n #(
        .N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .ARB_MODE(ARB_FIXED), .TIMEOUT_CYCLES(8)
    ) u_fix (
        .clk_i(clk), .rst_ni(rst_ni),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_dat_o(f_mdat),
        .m_ack_o(f_ack), .m_err_o(f_err), .m_stall_o(f_stall),
        .bus_cyc_o(f_cyc), .bus_stb_o(f_stb), .bus_we_o(f_we), .bus_sel_o(f_sel),
        .bus_adr_o(f_adr), .bus_dat_o(f_dat), .bus_dat_i(bus_dat_in),
        .bus_ack_i(bus_ack), .bus_err_i(bus_err), .bus_stall_i(bus_stall),
        .grant_o(f_grant), .timeout_o(f_timeout)
    );

    rv32i_wb_arbiter_n #(
        .N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .ARB_MODE(ARB_RR), .TIMEOUT_CYCLES(8)
    ) u_rr (
        .clk_i(clk), .rst_ni(rst_ni),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_dat_o(r_mdat),
        .m_ack_o(r_ack), .m_err_o(r_err), .m_stall_o(r_stall),
        .bus_cyc_o(r_cyc), .bus_stb_o(r_stb), .bus_we_o(r_we), .bus_sel_o(r_sel),
        .bus_adr_o(r_adr), .bus_dat_o(r_dat), .bus_dat_i(bus_dat_in),
        .bus_ack_i(bus_ack), .bus_err_i(bus_err), .bus_stall_i(bus_stall),
        .grant_o(r_grant), .timeout_o(r_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst_ni    = 1'b0;
        m_cyc     = '0;
        m_stb     = '0;
        bus_ack   = 1'b0;
        bus_err   = 1'b0;
        bus_stall = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int ord[5];
        ord = '{0, 1, 2, 3, 0};

        rst_ni     = 1'b1;
        m_cyc      = '0;
        m_stb      = '0;
        m_we       = 4'b1010;
        m_sel      = '1;
        bus_dat_in = 32'hCAFE_F00D;
        bus_ack    = 1'b0;
        bus_err    = 1'b0;
        bus_stall  = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_adr[i*AW +: AW] = 32'h1000_0000 + 32'(i * 16);
            m_dat[i*DW +: DW] = 32'hD000_0000 + 32'(i);
        end

        // ---------------- reset state ----------------
        #1 rst_ni = 1'b0;
        #2;
        check_val("rst_f_grant",   f_grant,   0);
        check_val("rst_f_cyc",     f_cyc,     0);
        check_val("rst_f_ack",     f_ack,     0);
        check_val("rst_f_err",     f_err,     0);
        check_val("rst_f_timeout", f_timeout, 0);
        check_val("rst_r_grant",   r_grant,   0);
        check_val("mdat_bcast",    f_mdat,    64'hCAFE_F00D);
        do_reset();

        // ---------------- round-robin rotation ----------------
        m_cyc = 4'hF;
        m_stb = 4'hF;
        settle();
        check_val("rr_idle_grant", r_grant, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_val("rr_grant", r_grant, 64'(1 << ord[k]));
            bus_ack = 1'b1;
            m_cyc[ord[k]] = 1'b0;
            m_stb[ord[k]] = 1'b0;
            settle();
            check_val("rr_ack", r_ack, 64'(1 << ord[k]));
            tick();
            bus_ack = 1'b0;
            m_cyc   = 4'hF;
            m_stb   = 4'hF;
            settle();
            check_val("rr_gap_grant", r_grant, 0);
        end

        // ---------------- fixed priority m1 vs m3 ----------------
        do_reset();
        m_cyc = 4'b1010;
        m_stb = 4'b1010;
        settle();
        check_val("fx_idle_grant", f_grant, 0);
        check_val("fx_idle_stall", f_stall, 4'b1010);
        tick();
        check_val("fx_grant_m1", f_grant, 4'b0010);
        check_val("fx_bus_cyc",  f_cyc,   1);
        check_val("fx_bus_adr",  f_adr,   32'h1000_0010);
        check_val("fx_bus_dat",  f_dat,   32'hD000_0001);
        check_val("fx_bus_we",   f_we,    1);
        check_val("fx_bus_sel",  f_sel,   4'hF);
        check_val("fx_stall",    f_stall, 4'b1000);
        bus_ack  = 1'b1;
        m_cyc[1] = 1'b0;
        m_stb[1] = 1'b0;
        settle();
        check_val("fx_ack_m1", f_ack, 4'b0010);
        tick();
        bus_ack = 1'b0;
        settle();
        check_val("fx_gap_grant", f_grant, 0);
        check_val("fx_gap_stall", f_stall, 4'b1000);
        tick();
        check_val("fx_grant_m3", f_grant, 4'b1000);
        check_val("fx_adr_m3",   f_adr,   32'h1000_0030);
        m_cyc = '0;
        m_stb = '0;
        tick();
        check_val("fx_release", f_grant, 0);

        // ---------------- burst lock ----------------
        do_reset();
        m_cyc = 4'b0100;
        m_stb = 4'b0100;
        tick();
        check_val("bl_grant_m2", f_grant, 4'b0100);
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
        for (int b = 0; b < 4; b++) begin
            bus_ack = 1'b1;
            settle();
            check_val("bl_ack_m2",   f_ack,   4'b0100);
            check_val("bl_stall_m0", f_stall, 4'b0001);
            tick();
        end
        bus_ack  = 1'b0;
        m_cyc[2] = 1'b0;
        m_stb[2] = 1'b0;
        settle();
        check_val("bl_no_ack", f_ack, 0);
        tick();
        check_val("bl_idle", f_grant, 0);
        tick();
        check_val("bl_grant_m0", f_grant, 4'b0001);

        // ---------------- watchdog fires ----------------
        do_reset();
        m_cyc = 4'b0010;
        m_stb = 4'b0010;
        tick();
        check_val("wd_grant", f_grant, 4'b0010);
        for (int c = 0; c < 8; c++) begin
            settle();
            check_val("wd_pre_err", f_err,     0);
            check_val("wd_pre_tmo", f_timeout, 0);
            tick();
        end
        check_val("wd_err",     f_err,     4'b0010);
        check_val("wd_timeout", f_timeout, 1);
        check_val("wd_bus_cyc", f_cyc,     0);
        tick();
        check_val("wd_post_err",   f_err,     0);
        check_val("wd_post_tmo",   f_timeout, 0);
        check_val("wd_post_grant", f_grant,   0);
        bus_ack = 1'b1;
        settle();
        check_val("late_ack_idle", f_ack, 0);
        bus_ack = 1'b0;
        m_cyc   = '0;
        m_stb   = '0;
        tick();

        // ---------------- ack on the firing cycle ----------------
        do_reset();
        m_cyc = 4'b0010;
        m_stb = 4'b0010;
        tick();
        repeat (7) tick();
        bus_ack = 1'b1;
        settle();
        check_val("edge_ack", f_ack,     4'b0010);
        check_val("edge_err", f_err,     0);
        check_val("edge_tmo", f_timeout, 0);
        tick();
        bus_ack = 1'b0;
        settle();
        check_val("edge_post_tmo",   f_timeout, 0);
        check_val("edge_post_err",   f_err,     0);
        check_val("edge_post_grant", f_grant,   4'b0010);
        m_cyc = '0;
        m_stb = '0;
        tick();
        check_val("edge_release", f_grant, 0);

        // ---------------- reset mid-burst, RR pointer restart ----------------
        do_reset();
        m_cyc = 4'hF;
        m_stb = 4'hF;
        tick();
        check_val("mr_grant_m0", r_grant, 4'b0001);
        bus_ack  = 1'b1;
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        tick();
        bus_ack = 1'b0;
        m_cyc   = 4'hF;
        m_stb   = 4'hF;
        tick();
        check_val("mr_grant_m1", r_grant, 4'b0010);
        check_val("mr_bus_cyc",  r_cyc,   1);
        bus_ack = 1'b1;
        settle();
        check_val("mr_ack_m1", r_ack, 4'b0010);
        #2 rst_ni = 1'b0;
        #1;
        check_val("mr_cyc_async",   r_cyc,     0);
        check_val("mr_grant_async", r_grant,   0);
        check_val("mr_ack_async",   r_ack,     0);
        check_val("mr_tmo_async",   r_timeout, 0);
        bus_ack = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        check_val("mr_first_grant", r_grant, 4'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
